// File: rtl/whack_pkg.sv
// Shared encodings for the whack-a-mole game core and its random source.
package whack_pkg;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_COUNTDOWN = 2'd1;
  localparam logic [1:0] ST_PLAY      = 2'd2;
  localparam logic [1:0] ST_OVER      = 2'd3;

  localparam logic [1:0] MODE_NONE = 2'd0;
  localparam logic [1:0] MODE_1    = 2'd1;
  localparam logic [1:0] MODE_2    = 2'd2;
  localparam logic [1:0] MODE_3    = 2'd3;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Right-shift Galois mask for taps 16,14,13,11.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  localparam logic [7:0] COUNTDOWN_SECS = 8'd3;

  // Mode button edges [1..3] mapped to a mode; the lowest button wins a tie.
  function automatic logic [1:0] pick_mode(input logic [2:0] rise);
    logic [1:0] m;
    m = MODE_NONE;
    if (rise[0])      m = MODE_1;
    else if (rise[1]) m = MODE_2;
    else if (rise[2]) m = MODE_3;
    return m;
  endfunction

endpackage

// File: rtl/mole_lfsr.sv
// 16-bit Galois LFSR used to pick the next mole; only the low OUT_W bits
// are exported since the core only needs an index's worth of randomness.
module mole_lfsr
  import whack_pkg::*;
#(
  parameter int OUT_W = 4
) (
  input  logic             clk_sys,
  input  logic             rst_b,
  input  logic             advance,
  output logic [OUT_W-1:0] value
);

  logic [15:0] lfsr;

  // Step once per spawned mole; seed is nonzero so the sequence never locks.
  always_ff @(posedge clk_sys or negedge rst_b) begin
    if (!rst_b) begin
      lfsr <= LFSR_SEED;
    end else if (advance) begin
      lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_TAPS : 16'h0000);
    end
  end

  assign value = lfsr[OUT_W-1:0];

endmodule

// File: rtl/whack_game_core.sv
// Whack-a-mole game sequencer: input sync, countdown/play timers, mole
// spawning, hit/miss scoring and adaptive speed-up.
//
//   state        | meaning
//   -------------+---------------------------------------------------
//   ST_IDLE      | no game; waiting for a mode button
//   ST_COUNTDOWN | 3-second lead-in before play
//   ST_PLAY      | moles lit, switches scored, game clock running
//   ST_OVER      | game finished; score and mode held for display
module whack_game_core #(
  parameter int NUM_MOLES      = 16,
  parameter int CYCLES_PER_SEC = 100_000_000,
  parameter int GAME_SECONDS   = 60,
  parameter int SCORE_W        = 14,
  parameter int MISS_PENALTY   = 0,
  parameter int ADAPTIVE       = 1,
  parameter int LEVEL_PTS      = 5
) (
  input  logic                 clock_i,
  input  logic                 reset_i,
  input  logic [3:0]           buttons_i,
  input  logic [NUM_MOLES-1:0] switches_i,
  output logic [NUM_MOLES-1:0] leds_o,
  output logic [SCORE_W-1:0]   score_o,
  output logic [7:0]           time_left_o,
  output logic [1:0]           state_o,
  output logic [1:0]           mode_o,
  output logic                 hit_pulse_o,
  output logic                 miss_pulse_o
);
  import whack_pkg::*;

  localparam int IDX_W = (NUM_MOLES > 1) ? $clog2(NUM_MOLES) : 1;
  localparam logic [31:0] CPS_M1   = 32'(CYCLES_PER_SEC - 1);
  localparam logic [31:0] BASE_1   = 32'(CYCLES_PER_SEC);
  localparam logic [31:0] BASE_2   = 32'(CYCLES_PER_SEC / 2);
  localparam logic [31:0] BASE_3   = 32'(CYCLES_PER_SEC / 5);
  localparam logic [31:0] MIN_PER  = 32'((CYCLES_PER_SEC / 10 > 0) ? CYCLES_PER_SEC / 10 : 1);
  localparam logic [31:0] LEVEL_M1 = 32'(LEVEL_PTS - 1);
  localparam logic [7:0]  GAME_T   = 8'(GAME_SECONDS);
  localparam logic [SCORE_W-1:0] SCORE_MAX = SCORE_W'(9999);

  logic [3:0]           btn_s1, btn_s2, btn_s3;
  logic [NUM_MOLES-1:0] sw_s1, sw_s2, sw_s3;

  logic [1:0]           state, mode;
  logic [SCORE_W-1:0]   score;
  logic [7:0]           time_left;
  logic [NUM_MOLES-1:0] leds;
  logic                 hit_pulse, miss_pulse;
  logic [31:0]          sec_cnt, mole_cnt, period, level_cnt;
  logic [IDX_W-1:0]     last_idx;

  logic [3:0]           btn_rise;
  logic [NUM_MOLES-1:0] sw_chg;
  logic                 restart, start_req, sec_tick, mole_tick, last_sec;
  logic                 hit, miss, spawn;
  logic [1:0]           start_mode;
  logic [31:0]          base_period, shrunk, period_lvl;
  logic [IDX_W-1:0]     lfsr_low, mod_idx, new_idx;
  logic [NUM_MOLES-1:0] new_leds;

  mole_lfsr #(.OUT_W(IDX_W)) u_lfsr (
    .clk_sys (clock_i),
    .rst_b   (reset_i),
    .advance (spawn),
    .value   (lfsr_low)
  );

  // Two-flop synchronisers plus one history stage for edge/change detect.
  // sw_s3 follows sw_s2 every cycle, so entering PLAY never sees a stale
  // switch difference.
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      btn_s1 <= '0; btn_s2 <= '0; btn_s3 <= '0;
      sw_s1  <= '0; sw_s2  <= '0; sw_s3  <= '0;
    end else begin
      btn_s1 <= buttons_i;  btn_s2 <= btn_s1; btn_s3 <= btn_s2;
      sw_s1  <= switches_i; sw_s2  <= sw_s1;  sw_s3  <= sw_s2;
    end
  end

  // Event decode, timer terminal counts and next-mole selection.
  always_comb begin
    btn_rise   = btn_s2 & ~btn_s3;
    sw_chg     = sw_s2 ^ sw_s3;
    restart    = btn_rise[0];
    start_req  = (btn_rise[3:1] != 3'b000);
    start_mode = pick_mode(btn_rise[3:1]);
    sec_tick   = (sec_cnt == 32'd0);
    mole_tick  = (mole_cnt == 32'd0);
    last_sec   = sec_tick && (time_left == 8'd1);
    hit        = (state == ST_PLAY) && ((sw_chg & leds) != '0);
    miss       = (state == ST_PLAY) && !hit && (sw_chg != '0);
    spawn      = !restart &&
                 (((state == ST_COUNTDOWN) && last_sec) ||
                  ((state == ST_PLAY) && mole_tick && !last_sec));

    case (start_mode)
      MODE_2:  base_period = BASE_2;
      MODE_3:  base_period = BASE_3;
      default: base_period = BASE_1;
    endcase
    shrunk     = period - (period >> 3);
    period_lvl = (shrunk < MIN_PER) ? MIN_PER : shrunk;

    mod_idx = (32'(lfsr_low) >= NUM_MOLES) ? lfsr_low - IDX_W'(NUM_MOLES) : lfsr_low;
    if (mod_idx == last_idx) begin
      new_idx = (32'(mod_idx) == NUM_MOLES - 1) ? '0 : mod_idx + IDX_W'(1);
    end else begin
      new_idx = mod_idx;
    end
    new_leds = {{(NUM_MOLES-1){1'b0}}, 1'b1} << new_idx;
  end

  // Game FSM with its second timer, mole timer, scoring and speed level.
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      state      <= ST_IDLE;
      mode       <= MODE_NONE;
      score      <= '0;
      time_left  <= '0;
      leds       <= '0;
      hit_pulse  <= 1'b0;
      miss_pulse <= 1'b0;
      sec_cnt    <= '0;
      mole_cnt   <= '0;
      period     <= '0;
      level_cnt  <= '0;
      last_idx   <= '0;
    end else begin
      hit_pulse  <= 1'b0;
      miss_pulse <= 1'b0;
      if (restart) begin
        state     <= ST_IDLE;
        mode      <= MODE_NONE;
        leds      <= '0;
        time_left <= '0;
        sec_cnt   <= '0;
        mole_cnt  <= '0;
      end else begin
        case (state)
          ST_IDLE, ST_OVER: begin
            if (start_req) begin
              state     <= ST_COUNTDOWN;
              mode      <= start_mode;
              score     <= '0;
              time_left <= COUNTDOWN_SECS;
              sec_cnt   <= CPS_M1;
              period    <= base_period;
              level_cnt <= '0;
              leds      <= '0;
            end
          end
          ST_COUNTDOWN: begin
            sec_cnt <= sec_tick ? CPS_M1 : sec_cnt - 32'd1;
            if (last_sec) begin
              state     <= ST_PLAY;
              time_left <= GAME_T;
              leds      <= new_leds;
              last_idx  <= new_idx;
              mole_cnt  <= period - 32'd1;
            end else if (sec_tick) begin
              time_left <= time_left - 8'd1;
            end
          end
          ST_PLAY: begin
            sec_cnt <= sec_tick ? CPS_M1 : sec_cnt - 32'd1;
            if (last_sec) begin
              state     <= ST_OVER;
              time_left <= '0;
              leds      <= '0;
            end else begin
              if (sec_tick) time_left <= time_left - 8'd1;
              if (mole_tick) begin
                leds     <= new_leds;
                last_idx <= new_idx;
                mole_cnt <= period - 32'd1;
              end else begin
                mole_cnt <= mole_cnt - 32'd1;
                if (hit) leds <= '0;
              end
            end
            // A speed-up takes effect at the next mole reload.
            if (hit) begin
              hit_pulse <= 1'b1;
              if (score < SCORE_MAX) score <= score + SCORE_W'(1);
              if (level_cnt == LEVEL_M1) begin
                level_cnt <= '0;
                if (ADAPTIVE != 0) period <= period_lvl;
              end else begin
                level_cnt <= level_cnt + 32'd1;
              end
            end else if (miss) begin
              miss_pulse <= 1'b1;
              if (MISS_PENALTY != 0 && score != '0) score <= score - SCORE_W'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign leds_o       = leds;
  assign score_o      = score;
  assign time_left_o  = time_left;
  assign state_o      = state;
  assign mode_o       = mode;
  assign hit_pulse_o  = hit_pulse;
  assign miss_pulse_o = miss_pulse;

endmodule

// File: doc/whack_game_core.md
WHACK_GAME_CORE -- requirements
Module: whack_game_core

Interface
REQ-001 SHALL have parameter NUM_MOLES, default 16, number of mole LEDs/switches (2..32).
REQ-002 SHALL have parameter CYCLES_PER_SEC, default 100_000_000, clock cycles per game second.
REQ-003 SHALL have parameter GAME_SECONDS, default 60, play duration in seconds (1..255).
REQ-004 SHALL have parameter SCORE_W, default 14, score width; score saturates at 9999.
REQ-005 SHALL have parameter MISS_PENALTY, default 0; 1 = wrong whack subtracts one point.
REQ-006 SHALL have parameter ADAPTIVE, default 1; 1 = mole period shrinks with score.
REQ-007 SHALL have parameter LEVEL_PTS, default 5, hits per speed-up step.
REQ-008 SHALL have ports: clock_i in 1 system clock; reset_i in 1 reset, asynchronous, active-low.
REQ-009 SHALL have ports: buttons_i in 4 raw buttons ([0] restart, [1..3] start mode 1..3); switches_i in NUM_MOLES raw whack switches.
REQ-010 SHALL have ports: leds_o out NUM_MOLES lit mole (one-hot or zero); score_o out SCORE_W; time_left_o out 8 seconds remaining.
REQ-011 SHALL have ports: state_o out 2 game state; mode_o out 2 active mode (0 = none); hit_pulse_o out 1; miss_pulse_o out 1.

Function
REQ-012 SHALL synchronise buttons_i and switches_i through two flops and act on rising edges (buttons) or any change (switches); an event acts on the 3rd clock edge after the input change.
REQ-013 SHALL implement states IDLE(0), COUNTDOWN(1), PLAY(2), OVER(3).
REQ-014 IDLE: leds_o=0, time_left_o=0; a button[1..3] edge sets mode_o=1..3, clears score_o, enters COUNTDOWN; simultaneous mode edges: lowest index wins.
REQ-015 COUNTDOWN: time_left_o=3, decrementing once per second; on reaching 0, enters PLAY with time_left_o=GAME_SECONDS and lights the first mole in the same cycle.
REQ-016 PLAY: time_left_o decrements every CYCLES_PER_SEC cycles; the cycle it reaches 0, enters OVER.
REQ-017 OVER: leds_o=0, score_o and mode_o held; only restart or a mode button leaves (mode button = new game per REQ-014).
REQ-018 A restart edge in any state SHALL enter IDLE next cycle, mode_o=0, leds_o=0; score_o held until the next start.
REQ-019 Base mole period in cycles: mode1 CYCLES_PER_SEC, mode2 CYCLES_PER_SEC/2, mode3 CYCLES_PER_SEC/5.
REQ-020 At each period expiry, SHALL light a new index from a 16-bit LFSR: idx = low bits, minus NUM_MOLES if >= NUM_MOLES, plus 1 (wrap) if equal to the previous index.
REQ-021 Hit: switch change at the lit index in PLAY -> hit_pulse_o high one cycle, score +1 (saturate 9999), LED off next cycle, no new mole until period expiry.
REQ-022 Miss: switch change at an unlit index in PLAY -> miss_pulse_o one cycle; if MISS_PENALTY, score -1 saturating at 0.
REQ-023 Several switches changing in one cycle: hit if any is the lit index, else at most one miss; hit and miss never pulse together.
REQ-024 Switch changes outside PLAY SHALL be ignored; synchronised switch state is re-captured on PLAY entry so no spurious event occurs.
REQ-025 If ADAPTIVE, every LEVEL_PTS hits: period = period - (period>>3), floored at CYCLES_PER_SEC/10; reset to base at each game start.

Reset
REQ-026 reset_i low SHALL asynchronously force IDLE, mode_o=0, leds_o=0, score_o=0, time_left_o=0, pulses 0, all counters 0, LFSR to nonzero seed 16'hACE1.
REQ-027 Reset mid-PLAY SHALL discard the game; no pulse on release.

Structure
REQ-028 State and mode encodings and the LFSR seed SHALL live in shared package whack_pkg.
REQ-029 The random source SHALL be sub-module mole_lfsr (16-bit Galois, taps 16,14,13,11, advance-enable input).
REQ-030 Display muxing, BCD conversion and SSD drive SHALL remain outside this block.

Verification (CYCLES_PER_SEC=20, GAME_SECONDS=5, NUM_MOLES=8)
REQ-031 Reset low mid-PLAY -> same cycle: state_o=0, leds_o=0, score_o=0, time_left_o=0.
REQ-032 buttons_i[1] edge -> COUNTDOWN 3,2,1 over 60 cycles, PLAY with time_left_o=5 and one LED lit, OVER after 100 more cycles, leds_o=0.
REQ-033 Toggle lit switch -> hit_pulse_o one cycle, score_o 0->1, LED off; toggle unlit with MISS_PENALTY=1 at score 0 -> miss_pulse_o, score stays 0.
REQ-034 ADAPTIVE=1, LEVEL_PTS=2, mode1 -> period 20, after 2 hits 18, after 4 hits 16; never below 2.
REQ-035 Restart edge mid-PLAY -> IDLE within 3 cycles, mode_o=0; subsequent switch toggles produce no pulses.
